// File: rtl/mux_recirc_sync_rx_if.sv
// rtl/mux_recirc_sync_rx_if.sv - source/sink bundle for the mux-recirculation synchroniser receiver
//
// Purpose: groups the source-side request/acknowledge/data signals and the
// destination-side valid/ready output stage of mux_recirc_sync_rx.
// Ports (signals):
//   src_data      source bus, held stable by the source until ack is seen
//   src_req       asynchronous request from the source domain
//   src_ack       registered acknowledge back to the source domain
//   out_data      captured word, held between captures
//   out_valid     out_data holds an unconsumed word
//   out_ready     downstream accepts out_data on out_valid && out_ready
//   stalled       a request is pending but the output stage is full
//   capture_count number of captures since reset, wrapping
// Modports: master = source/sink environment, slave = the receiver.

interface mux_recirc_sync_rx_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] src_data;
    logic              src_req;
    logic              src_ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              stalled;
    logic [CNT_W-1:0]  capture_count;

    modport master (
        output src_data, src_req, out_ready,
        input  src_ack, out_data, out_valid, stalled, capture_count
    );

    modport slave (
        input  src_data, src_req, out_ready,
        output src_ack, out_data, out_valid, stalled, capture_count
    );
endinterface

// File: rtl/mux_recirc_sync_rx.sv
// rtl/mux_recirc_sync_rx.sv - destination-side mux-recirculation synchroniser with valid/ready output
//
// Purpose: synchronises an asynchronous src_req into clk_dest, captures src_data
// through a load/hold mux into a one-entry output stage, and returns src_ack.
// Supports 2-phase (TOGGLE_MODE=1) or 4-phase (TOGGLE_MODE=0) handshakes.
// Ports:
//   clk_dest  destination clock, the only clock in the block
//   rst       synchronous active-high reset
//   bus       mux_recirc_sync_rx_if.slave (src_data/src_req/src_ack,
//             out_data/out_valid/out_ready, stalled, capture_count)

module mux_recirc_sync_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TOGGLE_MODE = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk_dest,
    input  logic               rst,
    mux_recirc_sync_rx_if.slave bus
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("mux_recirc_sync_rx: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DROP = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_q;
    logic [DATA_W-1:0]      data_q;
    logic                   valid_q;
    logic [CNT_W-1:0]       count_q;

    logic req_sync;
    logic new_req;
    logic can_load;
    logic capture;

    assign req_sync = sync[SYNC_STAGES-1];

    // In 2-phase mode a request is pending whenever the synchronised request
    // phase differs from the acknowledge phase; in 4-phase mode only a high
    // level seen while idle and not yet acknowledged counts.
    assign new_req = (TOGGLE_MODE != 0) ? (req_sync != ack_q)
                                        : (req_sync && !ack_q && (state == IDLE));

    // The output stage can take a word when empty or being drained this edge,
    // so a consume and a capture in the same cycle leave no bubble.
    assign can_load = !valid_q || bus.out_ready;
    assign capture  = new_req && can_load;

    always_ff @(posedge clk_dest) begin
        if (rst) begin
            sync    <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            state   <= IDLE;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.src_req};

            // Recirculating mux: src_data is only sampled on a capture edge.
            if (capture) begin
                data_q  <= bus.src_data;
                valid_q <= 1'b1;
                count_q <= count_q + 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end

            // Holding ack while stalled is what backpressures the source.
            if (TOGGLE_MODE != 0) begin
                state <= IDLE;
                if (capture) begin
                    ack_q <= ~ack_q;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (capture) begin
                            ack_q <= 1'b1;
                            state <= WAIT_DROP;
                        end
                    end
                    WAIT_DROP: begin
                        if (!req_sync) begin
                            ack_q <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.src_ack       = ack_q;
    assign bus.out_data      = data_q;
    assign bus.out_valid     = valid_q;
    assign bus.capture_count = count_q;
    assign bus.stalled       = new_req && !can_load;

endmodule
